// File: rtl/cache_refill_ctrl.sv
// Miss-refill engine: one miss at a time, per-set round-robin victim choice, burst or
// single-word read, early critical-word forward and a single fill-commit cycle.
module cache_refill_ctrl #(
    parameter int  WAYS   = 2,
    parameter int  SETS   = 256,
    parameter int  WORDS  = 4,
    parameter int  TAG_W  = 20,
    localparam int WAY_W  = $clog2(WAYS),
    localparam int IDX_W  = $clog2(SETS),
    localparam int OFF_W  = $clog2(WORDS) + 2,
    localparam int ADDR_W = TAG_W + IDX_W + OFF_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  miss_valid,
    output logic                  miss_ready,
    input  logic [IDX_W-1:0]      miss_idx,
    input  logic [TAG_W-1:0]      miss_tag,
    input  logic [OFF_W-1:0]      miss_offset,
    input  logic                  miss_uncache,
    output logic [WAY_W-1:0]      victim_way,
    output logic                  rd_req,
    input  logic                  rd_rdy,
    output logic                  rd_type,
    output logic [ADDR_W-1:0]     rd_addr,
    input  logic                  ret_valid,
    input  logic                  ret_last,
    input  logic [31:0]           ret_data,
    output logic                  crit_valid,
    output logic [31:0]           crit_data,
    output logic                  fill_valid,
    output logic [WAY_W-1:0]      fill_way,
    output logic [IDX_W-1:0]      fill_idx,
    output logic [TAG_W-1:0]      fill_tag,
    output logic [32*WORDS-1:0]   fill_line,
    output logic                  done,
    output logic                  protocol_err
);
    localparam int BEAT_W = OFF_W - 2;
    localparam logic [BEAT_W-1:0] LAST_WORD = BEAT_W'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, REQ, RECV, FILL} state_t;

    state_t              state;
    logic [IDX_W-1:0]    idx_q;
    logic [TAG_W-1:0]    tag_q;
    logic [BEAT_W-1:0]   word_q;
    logic                uncache_q;
    logic [BEAT_W-1:0]   beat_q;
    logic [32*WORDS-1:0] line_q;
    logic [WAY_W-1:0]    rr_ptr [SETS];

    logic [BEAT_W-1:0]   crit_word;
    logic [BEAT_W-1:0]   last_beat;
    logic                unused_offset_lsbs;

    // Uncached accesses return a single word, which is always beat 0.
    assign crit_word  = uncache_q ? '0 : word_q;
    assign last_beat  = uncache_q ? '0 : LAST_WORD;

    assign miss_ready = (state == IDLE);
    assign rd_req     = (state == REQ);
    assign rd_type    = rd_req & ~uncache_q;
    assign rd_addr    = !rd_req   ? '0 :
                        uncache_q ? {tag_q, idx_q, word_q, 2'b00} :
                                    {tag_q, idx_q, {OFF_W{1'b0}}};
    assign fill_line  = line_q;

    // Byte lanes within the word do not affect the refill.
    assign unused_offset_lsbs = ^miss_offset[1:0];

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples the values from before the clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            idx_q        <= '0;
            tag_q        <= '0;
            word_q       <= '0;
            uncache_q    <= 1'b0;
            beat_q       <= '0;
            victim_way   <= '0;
            crit_valid   <= 1'b0;
            crit_data    <= '0;
            fill_valid   <= 1'b0;
            fill_way     <= '0;
            fill_idx     <= '0;
            fill_tag     <= '0;
            done         <= 1'b0;
            protocol_err <= 1'b0;
            // NOTE: the pointer array and line buffer are reset on purpose; the
            // victim sequence and the visible fill_line must restart from zero.
            line_q       <= '0;
            for (int s = 0; s < SETS; s++) rr_ptr[s] <= '0;
        end else begin
            crit_valid <= 1'b0;
            fill_valid <= 1'b0;
            done       <= 1'b0;

            if (ret_valid && state != RECV) protocol_err <= 1'b1;

            case (state)
                IDLE: begin
                    if (miss_valid) begin
                        idx_q      <= miss_idx;
                        tag_q      <= miss_tag;
                        word_q     <= miss_offset[OFF_W-1:2];
                        uncache_q  <= miss_uncache;
                        victim_way <= rr_ptr[miss_idx];
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (rd_rdy) begin
                        beat_q <= '0;
                        state  <= RECV;
                    end
                end
                RECV: begin
                    if (ret_valid) begin
                        line_q[{beat_q, 5'b00000} +: 32] <= ret_data;
                        if (beat_q == crit_word) begin
                            crit_valid <= 1'b1;
                            crit_data  <= ret_data;
                        end
                        if (beat_q == last_beat) begin
                            if (ret_last && !uncache_q) begin
                                fill_valid <= 1'b1;
                                done       <= 1'b1;
                                fill_way   <= victim_way;
                                fill_idx   <= idx_q;
                                fill_tag   <= tag_q;
                                state      <= FILL;
                            end else begin
                                // Uncached completion, or an overrun past the final beat.
                                if (!ret_last) protocol_err <= 1'b1;
                                done  <= 1'b1;
                                state <= IDLE;
                            end
                        end else if (ret_last) begin
                            protocol_err <= 1'b1;
                            done         <= 1'b1;
                            state        <= IDLE;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                FILL: begin
                    rr_ptr[idx_q] <= rr_ptr[idx_q] + 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl: a 2-way/4-word instance and a 4-way/8-word
// instance, driven on the falling edge and observed on the falling edge.
module tb_cache_refill_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    // 2-way, 4-word instance
    logic         miss_valid, miss_ready, miss_uncache;
    logic [7:0]   miss_idx;
    logic [19:0]  miss_tag;
    logic [3:0]   miss_offset;
    logic         victim_way;
    logic         rd_req, rd_rdy, rd_type;
    logic [31:0]  rd_addr;
    logic         ret_valid, ret_last;
    logic [31:0]  ret_data;
    logic         crit_valid;
    logic [31:0]  crit_data;
    logic         fill_valid, fill_way;
    logic [7:0]   fill_idx;
    logic [19:0]  fill_tag;
    logic [127:0] fill_line;
    logic         done, protocol_err;

    // 4-way, 8-word instance
    logic         miss_valid_b, miss_ready_b;
    logic [7:0]   miss_idx_b;
    logic [19:0]  miss_tag_b;
    logic [4:0]   miss_offset_b;
    logic [1:0]   victim_way_b;
    logic         rd_req_b, rd_rdy_b, rd_type_b;
    logic [32:0]  rd_addr_b;
    logic         ret_valid_b, ret_last_b;
    logic [31:0]  ret_data_b;
    logic         crit_valid_b;
    logic [31:0]  crit_data_b;
    logic         fill_valid_b;
    logic [1:0]   fill_way_b;
    logic [7:0]   fill_idx_b;
    logic [19:0]  fill_tag_b;
    logic [255:0] fill_line_b;
    logic         done_b, protocol_err_b;

    cache_refill_ctrl #(.WAYS(2), .SETS(256), .WORDS(4), .TAG_W(20)) dut_a (
        .clk(clk), .reset(reset),
        .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_idx(miss_idx),
        .miss_tag(miss_tag), .miss_offset(miss_offset), .miss_uncache(miss_uncache),
        .victim_way(victim_way), .rd_req(rd_req), .rd_rdy(rd_rdy), .rd_type(rd_type),
        .rd_addr(rd_addr), .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .crit_valid(crit_valid), .crit_data(crit_data), .fill_valid(fill_valid),
        .fill_way(fill_way), .fill_idx(fill_idx), .fill_tag(fill_tag),
        .fill_line(fill_line), .done(done), .protocol_err(protocol_err)
    );

    cache_refill_ctrl #(.WAYS(4), .SETS(256), .WORDS(8), .TAG_W(20)) dut_b (
        .clk(clk), .reset(reset),
        .miss_valid(miss_valid_b), .miss_ready(miss_ready_b), .miss_idx(miss_idx_b),
        .miss_tag(miss_tag_b), .miss_offset(miss_offset_b), .miss_uncache(1'b0),
        .victim_way(victim_way_b), .rd_req(rd_req_b), .rd_rdy(rd_rdy_b), .rd_type(rd_type_b),
        .rd_addr(rd_addr_b), .ret_valid(ret_valid_b), .ret_last(ret_last_b),
        .ret_data(ret_data_b), .crit_valid(crit_valid_b), .crit_data(crit_data_b),
        .fill_valid(fill_valid_b), .fill_way(fill_way_b), .fill_idx(fill_idx_b),
        .fill_tag(fill_tag_b), .fill_line(fill_line_b), .done(done_b),
        .protocol_err(protocol_err_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // What one miss looked like from the outside
    int           n_crit, n_fill, n_done, crit_beat, fill_beat, done_beat;
    int           way_got, fway_got;
    logic         type_got;
    logic [32:0]  addr_got;
    logic [31:0]  crit_got;
    logic [255:0] line_got;
    logic [7:0]   fidx_got;
    logic [19:0]  ftag_got;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] line_of(input logic [31:0] base, input int n);
        logic [255:0] l = '0;
        for (int i = 0; i < n; i++) l[32*i +: 32] = base + 32'(i);
        return l;
    endfunction

    task automatic clear_record();
        n_crit = 0; n_fill = 0; n_done = 0;
        crit_beat = -1; fill_beat = -1; done_beat = -1;
        crit_got = '0; line_got = '0; fway_got = -1;
    endtask

    task automatic run_a(input logic [7:0] idx, input logic [19:0] tag, input logic [3:0] off,
                         input logic unc, input int rdy_dly, input int nbeats,
                         input logic [31:0] base);
        clear_record();
        @(negedge clk);
        check("a_miss_ready_idle", 256'(miss_ready), 1);
        miss_valid = 1'b1; miss_idx = idx; miss_tag = tag; miss_offset = off; miss_uncache = unc;
        @(negedge clk);
        miss_valid = 1'b0;
        check("a_rd_req_rise", 256'(rd_req), 1);
        way_got = int'(victim_way); type_got = rd_type; addr_got = 33'(rd_addr);
        rd_rdy = (rdy_dly == 0);
        for (int d = 1; d <= rdy_dly; d++) begin
            @(negedge clk);
            check("a_rd_req_hold", 256'(rd_req), 1);
            rd_rdy = (d == rdy_dly);
        end
        for (int c = 0; c < nbeats + 2; c++) begin
            @(negedge clk);
            rd_rdy = 1'b0;
            if (c == 0) check("a_rd_req_drop", 256'(rd_req), 0);
            if (crit_valid) begin n_crit++; crit_beat = c - 1; crit_got = crit_data; end
            if (fill_valid) begin
                n_fill++; fill_beat = c - 1; line_got = 256'(fill_line);
                fway_got = int'(fill_way); fidx_got = fill_idx; ftag_got = fill_tag;
            end
            if (done) begin n_done++; done_beat = c - 1; end
            ret_valid = (c < nbeats); ret_last = (c == nbeats - 1); ret_data = base + 32'(c);
        end
        ret_valid = 1'b0; ret_last = 1'b0;
        check("a_miss_ready_after", 256'(miss_ready), 1);
    endtask

    task automatic run_b(input logic [7:0] idx, input logic [19:0] tag, input logic [4:0] off,
                         input logic [31:0] base);
        clear_record();
        @(negedge clk);
        check("b_miss_ready_idle", 256'(miss_ready_b), 1);
        miss_valid_b = 1'b1; miss_idx_b = idx; miss_tag_b = tag; miss_offset_b = off;
        @(negedge clk);
        miss_valid_b = 1'b0;
        way_got = int'(victim_way_b); type_got = rd_type_b; addr_got = rd_addr_b;
        rd_rdy_b = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            rd_rdy_b = 1'b0;
            if (crit_valid_b) begin n_crit++; crit_beat = c - 1; crit_got = crit_data_b; end
            if (fill_valid_b) begin
                n_fill++; fill_beat = c - 1; line_got = fill_line_b;
                fway_got = int'(fill_way_b); fidx_got = fill_idx_b; ftag_got = fill_tag_b;
            end
            if (done_b) begin n_done++; done_beat = c - 1; end
            ret_valid_b = (c < 8); ret_last_b = (c == 7); ret_data_b = base + 32'(c);
        end
        ret_valid_b = 1'b0; ret_last_b = 1'b0;
    endtask

    // Checks common to every cached miss that should commit a fill
    task automatic expect_fill(input string t, input int way, input logic [31:0] base,
                               input int words, input int last);
        check({t, "_victim_way"}, 256'(way_got), 256'(way));
        check({t, "_fill_count"}, 256'(n_fill), 1);
        check({t, "_fill_way"},   256'(fway_got), 256'(way));
        check({t, "_fill_line"},  line_got, line_of(base, words));
        check({t, "_fill_beat"},  256'(fill_beat), 256'(last));
        check({t, "_done_count"}, 256'(n_done), 1);
        check({t, "_done_beat"},  256'(done_beat), 256'(last));
    endtask

    initial begin
        reset = 1'b1;
        miss_valid = 0; miss_idx = '0; miss_tag = '0; miss_offset = '0; miss_uncache = 0;
        rd_rdy = 0; ret_valid = 0; ret_last = 0; ret_data = '0;
        miss_valid_b = 0; miss_idx_b = '0; miss_tag_b = '0; miss_offset_b = '0;
        rd_rdy_b = 0; ret_valid_b = 0; ret_last_b = 0; ret_data_b = '0;
        repeat (3) @(negedge clk);

        check("rst_miss_ready",   256'(miss_ready), 1);
        check("rst_rd_req",       256'(rd_req), 0);
        check("rst_crit_valid",   256'(crit_valid), 0);
        check("rst_fill_valid",   256'(fill_valid), 0);
        check("rst_done",         256'(done), 0);
        check("rst_protocol_err", 256'(protocol_err), 0);
        check("rst_victim_way",   256'(victim_way), 0);
        check("rst_fill_line",    256'(fill_line), 0);
        check("rst_b_miss_ready", 256'(miss_ready_b), 1);
        check("rst_b_fill_line",  fill_line_b, 0);
        reset = 1'b0;

        // Cached miss, critical word 2, bridge accepts after two cycles
        run_a(8'd5, 20'h12345, 4'h8, 1'b0, 2, 4, 32'hD0D0_0000);
        check("t1_rd_type",    256'(type_got), 1);
        check("t1_rd_addr",    256'(addr_got), 256'(32'h1234_5050));
        check("t1_crit_count", 256'(n_crit), 1);
        check("t1_crit_beat",  256'(crit_beat), 2);
        check("t1_crit_data",  256'(crit_got), 256'(32'hD0D0_0002));
        check("t1_fill_idx",   256'(fidx_got), 5);
        check("t1_fill_tag",   256'(ftag_got), 256'(20'h12345));
        expect_fill("t1", 0, 32'hD0D0_0000, 4, 3);

        // Round robin on set 5, with an independent set 6 in between
        run_a(8'd5, 20'h00001, 4'h4, 1'b0, 0, 4, 32'h1111_0000);
        expect_fill("rr5_a", 1, 32'h1111_0000, 4, 3);
        run_a(8'd6, 20'h00002, 4'h0, 1'b0, 0, 4, 32'h2222_0000);
        expect_fill("rr6", 0, 32'h2222_0000, 4, 3);
        check("rr6_fill_idx", 256'(fidx_got), 6);
        run_a(8'd5, 20'h00003, 4'h0, 1'b0, 1, 4, 32'h3333_0000);
        expect_fill("rr5_b", 0, 32'h3333_0000, 4, 3);
        run_a(8'd5, 20'h00004, 4'hC, 1'b0, 0, 4, 32'h4444_0000);
        expect_fill("rr5_c", 1, 32'h4444_0000, 4, 3);
        check("rr5_c_crit_beat", 256'(crit_beat), 3);

        // Uncached single word at offset 0xC
        run_a(8'd5, 20'hABCDE, 4'hC, 1'b1, 1, 1, 32'hDEAD_BEEF);
        check("unc_rd_type",    256'(type_got), 0);
        check("unc_rd_addr",    256'(addr_got), 256'(32'hABCD_E05C));
        check("unc_victim",     256'(way_got), 0);
        check("unc_crit_beat",  256'(crit_beat), 0);
        check("unc_crit_data",  256'(crit_got), 256'(32'hDEAD_BEEF));
        check("unc_fill_count", 256'(n_fill), 0);
        check("unc_done_count", 256'(n_done), 1);
        check("unc_done_beat",  256'(done_beat), 0);
        check("unc_perr",       256'(protocol_err), 0);
        run_a(8'd5, 20'h00005, 4'h0, 1'b0, 0, 4, 32'h5555_0000);
        expect_fill("unc_after", 0, 32'h5555_0000, 4, 3);

        // Early ret_last on beat 1 of a cached line
        run_a(8'd5, 20'h00006, 4'h0, 1'b0, 0, 2, 32'h6666_0000);
        check("early_perr",       256'(protocol_err), 1);
        check("early_fill_count", 256'(n_fill), 0);
        check("early_done_count", 256'(n_done), 1);
        check("early_done_beat",  256'(done_beat), 1);
        run_a(8'd5, 20'h00007, 4'h4, 1'b0, 0, 4, 32'h7777_0000);
        expect_fill("early_after", 1, 32'h7777_0000, 4, 3);
        check("early_perr_sticky", 256'(protocol_err), 1);

        // 4-way, 8-word: five misses to set 0, critical word is the last beat
        for (int m = 0; m < 5; m++) begin
            run_b(8'd0, 20'h0BEE0 + 20'(m), 5'h1C, 32'hB000_0000 + 32'(m * 256));
            check($sformatf("b%0d_rd_type", m), 256'(type_got), 1);
            check($sformatf("b%0d_rd_addr", m), 256'(addr_got),
                  256'({20'h0BEE0 + 20'(m), 8'h00, 5'h00}));
            check($sformatf("b%0d_crit_beat", m), 256'(crit_beat), 7);
            check($sformatf("b%0d_crit_data", m), 256'(crit_got),
                  256'(32'hB000_0007 + 32'(m * 256)));
            expect_fill($sformatf("b%0d", m), m % 4, 32'hB000_0000 + 32'(m * 256), 8, 7);
        end
        check("b_perr", 256'(protocol_err_b), 0);

        // Reset in the middle of RECV abandons the miss
        @(negedge clk);
        miss_valid = 1'b1; miss_idx = 8'd9; miss_tag = 20'h0F00D; miss_offset = 4'h0; miss_uncache = 1'b0;
        @(negedge clk);
        miss_valid = 1'b0; rd_rdy = 1'b1;
        @(negedge clk);
        rd_rdy = 1'b0; ret_valid = 1'b1; ret_last = 1'b0; ret_data = 32'h5555_AAAA;
        @(negedge clk);
        ret_valid = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_miss_ready", 256'(miss_ready), 1);
        check("mid_rst_rd_req",     256'(rd_req), 0);
        check("mid_rst_rd_type",    256'(rd_type), 0);
        check("mid_rst_rd_addr",    256'(rd_addr), 0);
        check("mid_rst_crit_valid", 256'(crit_valid), 0);
        check("mid_rst_crit_data",  256'(crit_data), 0);
        check("mid_rst_fill_valid", 256'(fill_valid), 0);
        check("mid_rst_fill_line",  256'(fill_line), 0);
        check("mid_rst_done",       256'(done), 0);
        check("mid_rst_perr",       256'(protocol_err), 0);
        // Stray beat while idle
        ret_valid = 1'b1; ret_data = 32'h1234_5678;
        @(negedge clk);
        ret_valid = 1'b0;
        check("stray_perr",       256'(protocol_err), 1);
        check("stray_crit_valid", 256'(crit_valid), 0);
        check("stray_fill_line",  256'(fill_line), 0);
        repeat (2) begin
            @(negedge clk);
            check("post_rst_fill_valid", 256'(fill_valid), 0);
            check("post_rst_done",       256'(done), 0);
        end
        check("stray_perr_sticky", 256'(protocol_err), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
